// File: rtl/msg_checker.sv
// Scans the decrypted-message RAM and flags any byte that is not 'a'..'z' or space.
// Optional macro MSG_CHECK_EARLY_EXIT_EN: stop the scan at the first bad byte.
module msg_checker #(
    parameter int MSG_LEN = 32,
    parameter int ADDR_W  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start_sig,
    output logic [ADDR_W-1:0]            aAddr,
    input  logic [7:0]                   aQ,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [$clog2(MSG_LEN+1)-1:0] bad_count,
    output logic [ADDR_W-1:0]            first_bad
);

    // state | meaning
    // IDLE  | waiting for start_sig
    // PRIME | RAM registering address 0
    // SCAN  | checking one byte per cycle
    // DONE  | results held until next start
    typedef enum logic [1:0] {S_IDLE, S_PRIME, S_SCAN, S_DONE} state_t;

    localparam int                CNT_W     = $clog2(MSG_LEN + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MSG_LEN);

    state_t            state_q, state_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic [ADDR_W-1:0] chk_q, chk_nx;
    logic [CNT_W-1:0]  cnt_q, cnt_nx;
    logic [ADDR_W-1:0] first_q, first_nx;
    logic              found_q, found_nx;
    logic              pass_q, pass_nx;
    logic              byte_bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            chk_q   <= '0;
            cnt_q   <= '0;
            first_q <= '0;
            found_q <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_nx;
            addr_q  <= addr_nx;
            chk_q   <= chk_nx;
            cnt_q   <= cnt_nx;
            first_q <= first_nx;
            found_q <= found_nx;
            pass_q  <= pass_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        addr_nx  = addr_q;
        chk_nx   = chk_q;
        cnt_nx   = cnt_q;
        first_nx = first_q;
        found_nx = found_q;
        pass_nx  = pass_q;
        byte_bad = !(((aQ >= 8'h61) && (aQ <= 8'h7A)) || (aQ == 8'h20));

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_sig) begin
                    state_nx = S_PRIME;
                    addr_nx  = '0;
                    chk_nx   = '0;
                    cnt_nx   = '0;
                    first_nx = '0;
                    found_nx = 1'b0;
                    pass_nx  = 1'b0;
                end
            end
            S_PRIME: begin
                // a one-byte message keeps pointing at address 0
                if (LAST_ADDR != '0) addr_nx = ADDR_W'(1);
                state_nx = S_SCAN;
            end
            S_SCAN: begin
                chk_nx = chk_q + 1'b1;
                if (addr_q != LAST_ADDR) addr_nx = addr_q + 1'b1;
                if (byte_bad) begin
                    if (cnt_q != CNT_MAX) cnt_nx = cnt_q + 1'b1;
                    if (!found_q) begin
                        first_nx = chk_q;
                        found_nx = 1'b1;
                    end
                end
`ifdef MSG_CHECK_EARLY_EXIT_EN
                if (byte_bad) begin
                    state_nx = S_DONE;
                    pass_nx  = 1'b0;
                end else if (chk_q == LAST_ADDR) begin
                    state_nx = S_DONE;
                    pass_nx  = !found_q;
                end
`else
                if (chk_q == LAST_ADDR) begin
                    state_nx = S_DONE;
                    pass_nx  = !found_q && !byte_bad;
                end
`endif
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign aAddr     = addr_q;
    assign busy      = (state_q == S_PRIME) || (state_q == S_SCAN);
    assign done      = (state_q == S_DONE);
    assign pass      = pass_q;
    assign bad_count = cnt_q;
    assign first_bad = first_q;

endmodule

// File: tb/tb_msg_checker.sv
// Self-checking bench for msg_checker: RAM A model, vector table, corner sequences, random messages.
module tb_msg_checker;

    localparam int MSG_LEN = 32;
    localparam int ADDR_W  = 8;
    localparam int CNT_W   = $clog2(MSG_LEN + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              start_sig;
    logic [ADDR_W-1:0] aAddr;
    logic [7:0]        aQ;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  bad_count;
    logic [ADDR_W-1:0] first_bad;

    logic [7:0] mem [0:255];

    int n_cmp = 0;
    int n_err = 0;
    int overlap_err = 0;
    int range_err = 0;

    msg_checker #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start_sig(start_sig), .aAddr(aAddr), .aQ(aQ),
        .busy(busy), .done(done), .pass(pass), .bad_count(bad_count), .first_bad(first_bad)
    );

    always #5 clk = ~clk;

    always @(posedge clk) aQ <= mem[aAddr];

    always @(negedge clk) begin
        if (done && busy) overlap_err++;
        if (int'(aAddr) > MSG_LEN - 1) range_err++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit is_good(input logic [7:0] b);
        return (b == " ") || (b >= "a" && b <= "z");
    endfunction

    // Reference: scan the whole message with plain loops.
    function automatic void ref_model(output int p, output int c, output int f, output int lat);
        p = 1; c = 0; f = 0; lat = MSG_LEN + 1;
        for (int i = 0; i < MSG_LEN; i++) begin
            if (!is_good(mem[i])) begin
                if (p == 1) f = i;
                p = 0;
                c++;
`ifdef MSG_CHECK_EARLY_EXIT_EN
                c = 1;
                lat = i + 2;
                break;
`endif
            end
        end
    endfunction

    task automatic fill_a();
        for (int i = 0; i < 256; i++) mem[i] = "a";
    endtask

    // Pulse start, count edges until done; optional second start at edge E(restart_at).
    task automatic run_scan(input string name, input int restart_at, output int lat);
        int addr_bad;
        int exp_addr;
        addr_bad = 0;
        lat = -1;
        @(negedge clk);
        start_sig = 1'b1;
        @(posedge clk);
        #1;
        start_sig = (restart_at == 1);
        check({name, ".busy_after_start"}, int'(busy), 1);
        check({name, ".cleared"}, int'(pass) + int'(bad_count) + int'(first_bad) + int'(done), 0);
        if (aAddr != 0) addr_bad++;
        for (int n = 1; n < 200; n++) begin
            @(posedge clk);
            #1;
            start_sig = (n + 1 == restart_at);
            if (done) begin
                lat = n;
                break;
            end
            exp_addr = (n < MSG_LEN - 1) ? n : MSG_LEN - 1;
            if (int'(aAddr) != exp_addr) addr_bad++;
        end
        start_sig = 1'b0;
        check({name, ".addr_seq_errs"}, addr_bad, 0);
    endtask

    task automatic check_results(input string name, input int lat, input int ep, input int ec,
                                 input int ef, input int elat);
        check({name, ".latency"}, lat, elat);
        check({name, ".pass"}, int'(pass), ep);
        check({name, ".bad_count"}, int'(bad_count), ec);
        check({name, ".first_bad"}, int'(first_bad), ef);
        repeat (3) @(posedge clk);
        #1;
        check({name, ".done_held"}, int'(done), 1);
        check({name, ".count_held"}, int'(bad_count), ec);
    endtask

    typedef struct {
        logic [7:0] val;
        int         addr;
        int         exp_pass;
        int         exp_cnt;
        int         exp_first;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int lat, p, c, f, el;
        string msg;

        vecs[0] = '{8'h20,  5, 1, 0, 0};
        vecs[1] = '{8'h61,  0, 1, 0, 0};
        vecs[2] = '{8'h7A, 31, 1, 0, 0};
        vecs[3] = '{8'h1F,  3, 0, 1, 3};
        vecs[4] = '{8'h60,  7, 0, 1, 7};
        vecs[5] = '{8'h7B, 11, 0, 1, 11};
        vecs[6] = '{8'hFF, 20, 0, 1, 20};
        vecs[7] = '{8'h00, 31, 0, 1, 31};
        vecs[8] = '{8'h41,  0, 0, 1, 0};
        vecs[9] = '{8'h40, 16, 0, 1, 16};

        fill_a();
        reset = 1'b1;
        start_sig = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset.outputs", int'(aAddr) + int'(busy) + int'(done) + int'(pass)
              + int'(bad_count) + int'(first_bad), 0);

        // All good: "attack at dawn" padded with 'a'
        msg = "attack at dawn";
        fill_a();
        for (int i = 0; i < msg.len(); i++) mem[i] = msg[i];
        run_scan("all_good", 0, lat);
        check_results("all_good", lat, 1, 0, 0, 33);

        // Restart from DONE with a bad last byte
        mem[31] = 8'h41;
        run_scan("restart", 0, lat);
        check_results("restart", lat, 0, 1, 31, 33);

        // Boundary values
        fill_a();
        mem[0] = 8'h20; mem[1] = 8'h7A; mem[2] = 8'h61;
        mem[3] = 8'h1F; mem[7] = 8'h60; mem[11] = 8'h7B; mem[20] = 8'hFF; mem[31] = 8'h00;
        run_scan("bounds", 0, lat);
`ifdef MSG_CHECK_EARLY_EXIT_EN
        check_results("bounds", lat, 0, 1, 3, 5);
`else
        check_results("bounds", lat, 0, 5, 3, 33);
`endif

        // Start ignored while busy
        fill_a();
        run_scan("restart_busy", 10, lat);
        check_results("restart_busy", lat, 1, 0, 0, 33);

        // Reset in the middle of a scan
        fill_a();
        mem[2] = 8'h00;
        @(negedge clk);
        start_sig = 1'b1;
        @(posedge clk);
        #1;
        start_sig = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midreset.outputs", int'(aAddr) + int'(busy) + int'(done) + int'(pass)
              + int'(bad_count) + int'(first_bad), 0);
        repeat (3) @(posedge clk);
        #1;
        check("midreset.stays_idle", int'(busy) + int'(done), 0);
        mem[2] = "a";
        run_scan("after_reset", 0, lat);
        check_results("after_reset", lat, 1, 0, 0, 33);

        // Vector table: one probe byte in an otherwise good message
        for (int v = 0; v < 10; v++) begin
            fill_a();
            mem[vecs[v].addr] = vecs[v].val;
            run_scan($sformatf("vec%0d", v), 0, lat);
`ifdef MSG_CHECK_EARLY_EXIT_EN
            el = (vecs[v].exp_pass == 1) ? MSG_LEN + 1 : vecs[v].exp_first + 2;
`else
            el = MSG_LEN + 1;
`endif
            check_results($sformatf("vec%0d", v), lat, vecs[v].exp_pass, vecs[v].exp_cnt,
                          vecs[v].exp_first, el);
        end

        // Random messages against the reference model
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                if ($urandom_range(0, 9) == 0) mem[i] = 8'($urandom_range(0, 255));
                else if ($urandom_range(0, 5) == 0) mem[i] = 8'h20;
                else mem[i] = 8'($urandom_range(8'h61, 8'h7A));
            end
            ref_model(p, c, f, el);
            run_scan($sformatf("rnd%0d", t), 0, lat);
            check_results($sformatf("rnd%0d", t), lat, p, c, f, el);
        end

        check("done_busy_overlap", overlap_err, 0);
        check("addr_out_of_range", range_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
